// File: rtl/bmp_frame_arbiter_if.sv
// Bus bundle between the two BMP slave ports, the frame arbiter
// and the shared downstream processing path.
interface bmp_frame_arbiter_if #(
  parameter int DW = 32
);
  logic [1:0]    slv0_mode;
  logic          slv0_data_valid;
  logic [DW-1:0] slv0_data;
  logic          slv0_ready;
  logic [1:0]    slv1_mode;
  logic          slv1_data_valid;
  logic [DW-1:0] slv1_data;
  logic          slv1_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_mode;
  logic          out_hdr;
  logic          out_last;
  logic [1:0]    whos_grt;
  logic [31:0]   file_size;
  logic          hdr_err;
  logic          frame_done;

  modport master (
    output slv0_mode, slv0_data_valid, slv0_data,
    output slv1_mode, slv1_data_valid, slv1_data,
    output out_ready,
    input  slv0_ready, slv1_ready,
    input  out_data, out_valid, out_mode,
    input  out_hdr, out_last, whos_grt,
    input  file_size, hdr_err, frame_done
  );

  modport slave (
    input  slv0_mode, slv0_data_valid, slv0_data,
    input  slv1_mode, slv1_data_valid, slv1_data,
    input  out_ready,
    output slv0_ready, slv1_ready,
    output out_data, out_valid, out_mode,
    output out_hdr, out_last, whos_grt,
    output file_size, hdr_err, frame_done
  );
endinterface

// File: rtl/bmp_frame_arbiter.sv
// Frame-level round-robin arbiter: grants one slave per BMP frame,
// forwards its beats and parses the size/signature header fields.
module bmp_frame_arbiter #(
  parameter int DATA_BUS_SIZE = 32,
  parameter int HDR_BYTES     = 56
) (
  input logic             clk,
  input logic             rst_n,
  bmp_frame_arbiter_if.slave bus
);

  localparam logic [30:0] HDR_BEATS =
    31'(HDR_BYTES / 4);

  typedef enum logic [1:0] {
    IDLE, HEADER, BODY, DONE
  } state_t;

  state_t state, state_nx;

  logic        gnt;
  logic        last_srv;
  logic [1:0]  mode_q;
  logic [30:0] beat_cnt;
  logic [30:0] total_beats;
  logic [31:0] hdr0;
  logic [31:0] fs_q;
  logic        err_q;

  logic req0, req1, pick;
  logic active, sel_valid, accept;
  logic last_beat, fs_err;
  logic [DATA_BUS_SIZE-1:0] sel_data;
  logic [31:0] fs_new;

  assign req0 = bus.slv0_data_valid &&
    (bus.slv0_mode == 2'b01 ||
     bus.slv0_mode == 2'b10);
  assign req1 = bus.slv1_data_valid &&
    (bus.slv1_mode == 2'b01 ||
     bus.slv1_mode == 2'b10);

  // pick=1 selects slave1; on a tie the one not served last wins
  assign pick = (req0 && req1) ? ~last_srv : req1;

  assign active = (state == HEADER) ||
                  (state == BODY);

  assign sel_valid = gnt ? bus.slv1_data_valid
                         : bus.slv0_data_valid;
  assign sel_data  = gnt ? bus.slv1_data
                         : bus.slv0_data;

  assign accept = active && sel_valid &&
                  bus.out_ready;

  assign fs_new = {sel_data[23:16],
                   sel_data[31:24],
                   hdr0[7:0],
                   hdr0[15:8]};

  assign fs_err = (hdr0[31:24] != 8'h42) ||
                  (hdr0[23:16] != 8'h4D) ||
                  (fs_new < 32'(HDR_BYTES));

  // total_beats is cleared at grant so the
  // compare cannot fire before beat1 is seen
  assign last_beat = err_q
    ? (beat_cnt == HDR_BEATS - 31'd1)
    : (beat_cnt == total_beats - 31'd1);

  assign bus.out_valid  = active && sel_valid;
  assign bus.out_data   = active ? sel_data : '0;
  assign bus.out_mode   = active ? mode_q : 2'b00;
  assign bus.out_hdr    = active &&
                          (beat_cnt < HDR_BEATS);
  assign bus.out_last   = active && last_beat;
  assign bus.whos_grt   = active ? {1'b0, gnt}
                                 : 2'b10;
  assign bus.slv0_ready = active && !gnt &&
                          bus.out_ready;
  assign bus.slv1_ready = active && gnt &&
                          bus.out_ready;
  assign bus.file_size  = fs_q;
  assign bus.hdr_err    = err_q;
  assign bus.frame_done = (state == DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (req0 || req1)
          state_nx = HEADER;
      end
      HEADER: begin
        if (accept && last_beat)
          state_nx = DONE;
        else if (accept &&
                 beat_cnt == HDR_BEATS - 31'd1)
          state_nx = BODY;
      end
      BODY: begin
        if (accept && last_beat)
          state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt         <= 1'b0;
      last_srv    <= 1'b1;
      mode_q      <= 2'b00;
      beat_cnt    <= '0;
      total_beats <= '0;
      hdr0        <= '0;
      fs_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (req0 || req1)) begin
        gnt         <= pick;
        mode_q      <= pick ? bus.slv1_mode
                            : bus.slv0_mode;
        beat_cnt    <= '0;
        total_beats <= '0;
        fs_q        <= '0;
        err_q       <= 1'b0;
      end
      if (accept) begin
        beat_cnt <= beat_cnt + 31'd1;
        if (beat_cnt == 31'd0)
          hdr0 <= sel_data;
        if (beat_cnt == 31'd1) begin
          fs_q        <= fs_new;
          total_beats <= 31'(({1'b0, fs_new} +
                              33'd3) >> 2);
          err_q       <= fs_err;
        end
      end
      if (state == DONE)
        last_srv <= gnt;
    end
  end

endmodule

// File: tb/tb_bmp_frame_arbiter.sv
// Directed bench for bmp_frame_arbiter: frames from both slaves,
// tie-break, short/bad headers, backpressure and async reset.
module tb_bmp_frame_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  bmp_frame_arbiter_if bus ();

  bmp_frame_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] beat(
    input int s, input int idx,
    input logic [7:0] b0, input logic [7:0] b1,
    input logic [31:0] fs);
    logic [31:0] i;
    i = 32'(idx);
    if (idx == 0)
      return {b0, b1, fs[7:0], fs[15:8]};
    if (idx == 1)
      return {fs[23:16], fs[31:24], 16'h5A5A};
    return {4'hA, 4'(s), 8'h3C, i[15:0]};
  endfunction

  task automatic drive(input int s,
                       input logic [1:0] md,
                       input logic v,
                       input logic [31:0] d);
    if (s == 0) begin
      bus.slv0_mode       = md;
      bus.slv0_data_valid = v;
      bus.slv0_data       = d;
    end else begin
      bus.slv1_mode       = md;
      bus.slv1_data_valid = v;
      bus.slv1_data       = d;
    end
  endtask

  task automatic send_frame(
    input int s, input logic [1:0] md,
    input logic [7:0] b0, input logic [7:0] b1,
    input logic [31:0] fs, input bit tog,
    input bit gaps, input int abort_at);
    int   nb, idx, cyc;
    bit   herr;
    logic v, acc, own, oth;
    logic [31:0] d;
    herr = (b0 != 8'h42) || (b1 != 8'h4D) ||
           (fs < 32'd56);
    nb  = herr ? 14 : int'((fs + 32'd3) / 4);
    idx = 0;
    cyc = 0;
    while (idx < nb) begin
      @(negedge clk);
      if (abort_at >= 0 && idx == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_grt", 32'(bus.whos_grt), 32'd2);
        check("rst_rdy",
              32'(bus.slv0_ready | bus.slv1_ready),
              32'd0);
        check("rst_vld", 32'(bus.out_valid), 32'd0);
        drive(s, 2'b00, 1'b0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      d = beat(s, idx, b0, b1, fs);
      v = gaps ? (cyc % 3 != 2) : 1'b1;
      drive(s, md, v, d);
      bus.out_ready = tog ? cyc[0] : 1'b1;
      #1;
      own = (s == 0) ? bus.slv0_ready : bus.slv1_ready;
      oth = (s == 0) ? bus.slv1_ready : bus.slv0_ready;
      check("oth_rdy", 32'(oth), 32'd0);
      if (!bus.out_ready)
        check("rdy_hold", 32'(own), 32'd0);
      acc = v && own;
      if (acc) begin
        check("grt", 32'(bus.whos_grt), 32'(s));
        check("mode", 32'(bus.out_mode), 32'(md));
        check("data", bus.out_data, d);
        check("hdr", 32'(bus.out_hdr),
              32'(idx < 14));
        check("last", 32'(bus.out_last),
              32'(idx == nb - 1));
        idx++;
      end
      cyc++;
      if (cyc > 3000) begin
        check("timeout", 32'(idx), 32'(nb));
        break;
      end
    end
    @(negedge clk);
    drive(s, 2'b00, 1'b0, 32'd0);
    bus.out_ready = 1'b1;
    #1;
    check("done", 32'(bus.frame_done), 32'd1);
    check("done_grt", 32'(bus.whos_grt), 32'd2);
    check("fsize", bus.file_size, fs);
    check("herr", 32'(bus.hdr_err), 32'(herr));
    @(negedge clk);
    #1;
    check("done_pulse", 32'(bus.frame_done), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(0, 2'b00, 1'b0, 32'd0);
    drive(1, 2'b00, 1'b0, 32'd0);
    bus.out_ready = 1'b1;
    #1;
    check("r_grt", 32'(bus.whos_grt), 32'd2);
    check("r_mode", 32'(bus.out_mode), 32'd0);
    check("r_fs", bus.file_size, 32'd0);
    check("r_err", 32'(bus.hdr_err), 32'd0);
    check("r_done", 32'(bus.frame_done), 32'd0);
    check("r_vld", 32'(bus.out_valid), 32'd0);
    check("r_rdy",
          32'(bus.slv0_ready | bus.slv1_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // both slaves request in the same cycle
    @(negedge clk);
    drive(0, 2'b01, 1'b1,
          beat(0, 0, 8'h42, 8'h4D, 32'd64));
    drive(1, 2'b10, 1'b1,
          beat(1, 0, 8'h42, 8'h4D, 32'd72));
    send_frame(0, 2'b01, 8'h42, 8'h4D, 32'd64,
               1'b0, 1'b0, -1);
    send_frame(1, 2'b10, 8'h42, 8'h4D, 32'd72,
               1'b0, 1'b0, -1);

    send_frame(0, 2'b01, 8'h42, 8'h4D, 32'd64,
               1'b0, 1'b0, -1);
    send_frame(1, 2'b01, 8'h42, 8'h4D, 32'd58,
               1'b0, 1'b0, -1);
    send_frame(0, 2'b10, 8'h41, 8'h4D, 32'd64,
               1'b0, 1'b0, -1);
    send_frame(1, 2'b01, 8'h42, 8'h4D, 32'd60,
               1'b0, 1'b0, -1);
    send_frame(0, 2'b01, 8'h42, 8'h4D, 32'd100,
               1'b1, 1'b1, -1);
    send_frame(1, 2'b10, 8'h42, 8'h4D, 32'd120,
               1'b0, 1'b0, 20);
    send_frame(0, 2'b01, 8'h42, 8'h4D, 32'd64,
               1'b0, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
